// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator behind a 2-entry elastic output buffer
module imm_gen_pipe #(
    parameter int XLEN       = 32,
    parameter bit AUTO_FMT   = 1'b1,
    parameter bit SHAMT_MASK = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      fmt_ctrl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            has_imm,
    output logic            illegal
);
    localparam int EW = XLEN + 5;
    localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2;
    localparam logic [2:0] FMT_U = 3'b000, FMT_I = 3'b001, FMT_S = 3'b010, FMT_J = 3'b100, FMT_B = 3'b110;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_LOAD = 7'b0000011, OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_IMM32 = 7'b0011011, OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OP = 7'b0110011, OP_OP32 = 7'b0111011;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [2:0]      dec_fmt, sel_fmt;
    logic            dec_has, dec_ill, sel_has, sel_ill, is_shift;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh, sel_imm;
    logic [EW-1:0]   new_e, out_q, out_d, skid_q, skid_d;
    logic [1:0]      state_q, state_d;
    logic            in_ready_q, in_ready_d, accept, drain;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // classify the opcode into an immediate format, no-immediate or illegal
    always_comb begin
        dec_fmt = FMT_U;
        dec_has = 1'b1;
        dec_ill = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC: dec_fmt = FMT_U;
            OP_JAL: dec_fmt = FMT_J;
            OP_JALR, OP_LOAD, OP_IMM, OP_IMM32, OP_FENCE, OP_SYSTEM: dec_fmt = FMT_I;
            OP_STORE: dec_fmt = FMT_S;
            OP_BRANCH: dec_fmt = FMT_B;
            OP_OP, OP_OP32: dec_has = 1'b0;
            default: begin
                dec_has = 1'b0;
                dec_ill = 1'b1;
            end
        endcase
    end

    assign imm_i  = XLEN'($signed(instr[31:20]));
    assign imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b  = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_j  = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
    // shamt[5] only exists for 64-bit OP-IMM shifts; OP-IMM-32 is always 5 bits
    assign imm_sh = XLEN'({instr[25] && (opcode == OP_IMM) && (XLEN == 64), instr[24:20]});

    assign is_shift = (opcode == OP_IMM || opcode == OP_IMM32) && funct3[1:0] == 2'b01;
    assign sel_fmt  = AUTO_FMT ? dec_fmt : fmt_ctrl;
    assign sel_has  = AUTO_FMT ? dec_has : 1'b1;
    assign sel_ill  = AUTO_FMT ? dec_ill : 1'b0;

    // pick the immediate for the applied format, zero when there is none
    always_comb begin
        sel_imm = !sel_has ? '0 :
                  (AUTO_FMT && SHAMT_MASK && is_shift) ? imm_sh :
                  sel_fmt[0] ? imm_i :
                  sel_fmt[2:1] == 2'b00 ? imm_u :
                  sel_fmt[2:1] == 2'b01 ? imm_s :
                  sel_fmt[2:1] == 2'b10 ? imm_j : imm_b;
    end

    assign new_e  = {sel_imm, sel_fmt, sel_has, sel_ill};
    assign accept = in_valid && in_ready_q;
    assign drain  = (state_q != EMPTY) && out_ready;

    // occupancy transitions of the output register plus skid register
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    state_d = accept ? ONE : EMPTY;
                    out_d   = accept ? new_e : out_q;
                end
                ONE: begin
                    state_d = (accept && !drain) ? TWO : (!accept && drain) ? EMPTY : ONE;
                    out_d   = (accept && drain) ? new_e : out_q;
                    skid_d  = (accept && !drain) ? new_e : skid_q;
                end
                TWO: begin
                    state_d = drain ? ONE : TWO;
                    out_d   = drain ? skid_q : out_q;
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = state_d != TWO;
    end

    // buffer state and registered ready, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
        end
    end

    assign {imm, fmt, has_imm, illegal} = out_q;
    assign out_valid = state_q != EMPTY;
    assign in_ready  = in_ready_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed and randomized checks of imm_gen_pipe against a behavioural model
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] instr;
    logic [2:0]  fmt_ctrl;
    logic        ir[4], ov[4], ho[4], io[4];
    logic [2:0]  fo[4];
    logic [31:0] im0, im1, im3;
    logic [63:0] im2;
    int          checks = 0, errors = 0;
    int          xl[4] = '{32, 32, 64, 32};
    bit          au[4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bit          mk[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [6:0]  ops[14] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13, 7'h1b,
                             7'h0f, 7'h73, 7'h23, 7'h63, 7'h33, 7'h3b, 7'h13};

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .AUTO_FMT(1'b1), .SHAMT_MASK(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .instr(instr), .fmt_ctrl(fmt_ctrl), .out_valid(ov[0]), .out_ready(out_ready),
        .imm(im0), .fmt(fo[0]), .has_imm(ho[0]), .illegal(io[0]));
    imm_gen_pipe #(.XLEN(32), .AUTO_FMT(1'b1), .SHAMT_MASK(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .instr(instr), .fmt_ctrl(fmt_ctrl), .out_valid(ov[1]), .out_ready(out_ready),
        .imm(im1), .fmt(fo[1]), .has_imm(ho[1]), .illegal(io[1]));
    imm_gen_pipe #(.XLEN(64), .AUTO_FMT(1'b1), .SHAMT_MASK(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .instr(instr), .fmt_ctrl(fmt_ctrl), .out_valid(ov[2]), .out_ready(out_ready),
        .imm(im2), .fmt(fo[2]), .has_imm(ho[2]), .illegal(io[2]));
    imm_gen_pipe #(.XLEN(32), .AUTO_FMT(1'b0), .SHAMT_MASK(1'b1)) u3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[3]),
        .instr(instr), .fmt_ctrl(fmt_ctrl), .out_valid(ov[3]), .out_ready(out_ready),
        .imm(im3), .fmt(fo[3]), .has_imm(ho[3]), .illegal(io[3]));

    function automatic logic [68:0] obs(input int k);
        logic [63:0] v;
        v = k == 0 ? {32'b0, im0} : k == 1 ? {32'b0, im1} : k == 2 ? im2 : {32'b0, im3};
        return {v, fo[k], ho[k], io[k]};
    endfunction

    function automatic logic [68:0] model(input logic [31:0] ins, input logic [2:0] fc, input int k);
        logic [63:0] s, v;
        logic [2:0]  f;
        logic        h, il;
        int          op, f3;
        op = int'(ins & 32'h7f);
        f3 = int'((ins >> 12) & 32'h7);
        s  = ins[31] ? '1 : '0;
        h  = 1'b1;
        il = 1'b0;
        f  = 3'b000;
        if (au[k]) begin
            case (op)
                'h37, 'h17: f = 3'b000;
                'h6f: f = 3'b100;
                'h67, 'h03, 'h13, 'h1b, 'h0f, 'h73: f = 3'b001;
                'h23: f = 3'b010;
                'h63: f = 3'b110;
                'h33, 'h3b: h = 1'b0;
                default: begin h = 1'b0; il = 1'b1; end
            endcase
        end else f = fc;
        if (!h) v = '0;
        else if (f[0]) v = (s << 12) | 64'((ins >> 20) & 32'hfff);
        else case (f[2:1])
            2'b00: v = (s << 32) | 64'(ins & 32'hfffff000);
            2'b01: v = (s << 12) | 64'(((ins >> 25) & 32'h7f) << 5) | 64'((ins >> 7) & 32'h1f);
            2'b10: v = (s << 20) | 64'(((ins >> 12) & 32'hff) << 12) | 64'(((ins >> 20) & 32'h1) << 11)
                       | 64'(((ins >> 21) & 32'h3ff) << 1);
            default: v = (s << 12) | 64'(((ins >> 7) & 32'h1) << 11) | 64'(((ins >> 25) & 32'h3f) << 5)
                         | 64'(((ins >> 8) & 32'hf) << 1);
        endcase
        if (au[k] && mk[k] && (op == 'h13 || op == 'h1b) && (f3 == 1 || f3 == 5))
            v = (op == 'h13 && xl[k] == 64) ? 64'((ins >> 20) & 32'h3f) : 64'((ins >> 20) & 32'h1f);
        if (xl[k] == 32) v = v & 64'hffff_ffff;
        return {v, f, h, il};
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        int          p;
        w = $urandom;
        p = $urandom_range(0, 15);
        if (p < 14) w[6:0] = ops[p];
        return w;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0; fmt_ctrl = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++; if (ov[k] !== 1'b0) begin errors++; $display("FAIL reset_out_valid[%0d] got %b want 0", k, ov[k]); end
            checks++; if (ir[k] !== 1'b0) begin errors++; $display("FAIL reset_in_ready[%0d] got %b want 0", k, ir[k]); end
            checks++; if (obs(k) !== 69'd0) begin errors++; $display("FAIL reset_outputs[%0d] got %h want 0", k, obs(k)); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++; if (ir[k] !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready[%0d] got %b want 1", k, ir[k]); end
            checks++; if (ov[k] !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid[%0d] got %b want 0", k, ov[k]); end
        end
    endtask

    task automatic test_directed;
        logic [31:0] w[10] = '{32'hFFF00093, 32'hFE112E23, 32'h123452B7, 32'hFE000CE3, 32'h4030D093,
                               32'h4030D093, 32'h800002B7, 32'h002081B3, 32'h0000007F, 32'h800000EF};
        int          id[10] = '{0, 0, 0, 0, 0, 1, 2, 2, 2, 3};
        logic [68:0] ex[10] = '{{64'hFFFFFFFF, 3'b001, 1'b1, 1'b0}, {64'hFFFFFFFC, 3'b010, 1'b1, 1'b0},
                                {64'h12345000, 3'b000, 1'b1, 1'b0}, {64'hFFFFFFF8, 3'b110, 1'b1, 1'b0},
                                {64'h00000003, 3'b001, 1'b1, 1'b0}, {64'h00000403, 3'b001, 1'b1, 1'b0},
                                {64'hFFFFFFFF80000000, 3'b000, 1'b1, 1'b0}, {64'h0, 3'b000, 1'b0, 1'b0},
                                {64'h0, 3'b000, 1'b0, 1'b1}, {64'hFFF00000, 3'b100, 1'b1, 1'b0}};
        fmt_ctrl = 3'b100;
        out_ready = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            @(posedge clk); #1;
            in_valid = i < 10;
            if (i < 10) instr = w[i];
            @(negedge clk);
            if (i < 10) begin
                checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL dir_in_ready[%0d] got %b want 1", i, ir[0]); end
            end
            if (i > 0) begin
                checks++; if (ov[id[i-1]] !== 1'b1) begin errors++; $display("FAIL dir_out_valid[%0d] got %b want 1", i - 1, ov[id[i-1]]); end
                checks++; if (obs(id[i-1]) !== ex[i-1]) begin errors++; $display("FAIL dir_result[%0d] got %h want %h", i - 1, obs(id[i-1]), ex[i-1]); end
            end
        end
        @(negedge clk);
        checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL dir_idle got %b want 0", ov[0]); end
    endtask

    task automatic test_backpressure;
        logic [31:0] w[3];
        int          acc = 0;
        for (int i = 0; i < 3; i++) w[i] = rnd_instr();
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            instr = w[acc > 2 ? 2 : acc];
            @(negedge clk);
            if (c >= 1) begin
                checks++;
                if (ov[0] !== 1'b1 || obs(0) !== model(w[0], fmt_ctrl, 0)) begin
                    errors++; $display("FAIL bp_hold[%0d] got v=%b %h want v=1 %h", c, ov[0], obs(0), model(w[0], fmt_ctrl, 0));
                end
            end
            if (ir[0]) acc++;
        end
        checks++; if (acc !== 2) begin errors++; $display("FAIL bp_accepted got %0d want 2", acc); end
        checks++; if (ir[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", ir[0]); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i < 2) begin
                checks++;
                if (ov[0] !== 1'b1 || obs(0) !== model(w[i], fmt_ctrl, 0)) begin
                    errors++; $display("FAIL bp_drain[%0d] got v=%b %h want v=1 %h", i, ov[0], obs(0), model(w[i], fmt_ctrl, 0));
                end
            end else begin
                checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", ov[0]); end
            end
        end
    endtask

    task automatic test_flush;
        logic [31:0] d;
        d = rnd_instr();
        out_ready = 1'b0;
        @(posedge clk); #1; in_valid = 1'b1; instr = rnd_instr();
        @(posedge clk); #1; instr = rnd_instr();
        @(posedge clk); #1; instr = rnd_instr(); flush = 1'b1;
        @(negedge clk);
        checks++; if (ir[0] !== 1'b0) begin errors++; $display("FAIL flush_pre_full got %b want 0", ir[0]); end
        @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", ov[0]); end
        checks++; if (ir[0] !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %b want 1", ir[0]); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL flush_ghost[%0d] got %b want 0", i, ov[0]); end
        end
        @(posedge clk); #1; in_valid = 1'b1; instr = d;
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ov[0] !== 1'b1 || obs(0) !== model(d, fmt_ctrl, 0)) begin
            errors++; $display("FAIL flush_after got v=%b %h want v=1 %h", ov[0], obs(0), model(d, fmt_ctrl, 0));
        end
    endtask

    task automatic test_async_reset;
        out_ready = 1'b1;
        fmt_ctrl = 3'b100;
        @(posedge clk); #1; in_valid = 1'b1; instr = 32'hFFF00093;
        @(posedge clk); #1; in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ov[0] !== 1'b0) begin errors++; $display("FAIL areset_out_valid got %b want 0", ov[0]); end
        checks++; if (obs(0) !== 69'd0) begin errors++; $display("FAIL areset_outputs got %h want 0", obs(0)); end
        checks++; if (ir[0] !== 1'b0) begin errors++; $display("FAIL areset_in_ready got %b want 0", ir[0]); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (ir[3] !== 1'b1) begin errors++; $display("FAIL areset_release got %b want 1", ir[3]); end
        in_valid = 1'b1; instr = 32'h800000EF;
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ov[3] !== 1'b1 || obs(3) !== {64'hFFF00000, 3'b100, 1'b1, 1'b0}) begin
            errors++; $display("FAIL manual_j got v=%b %h want v=1 %h", ov[3], obs(3), {64'hFFF00000, 3'b100, 1'b1, 1'b0});
        end
        checks++;
        if (obs(0) !== model(32'h800000EF, 3'b100, 0)) begin
            errors++; $display("FAIL areset_auto_j got %h want %h", obs(0), model(32'h800000EF, 3'b100, 0));
        end
    endtask

    task automatic test_random;
        logic [34:0] q[$];
        logic        can_in;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            in_valid  = $urandom_range(0, 9) < 7;
            instr     = rnd_instr();
            fmt_ctrl  = 3'($urandom);
            out_ready = $urandom_range(0, 9) < 6;
            flush     = $urandom_range(0, 49) == 0;
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                checks++; if (ir[k] !== (q.size() < 2)) begin errors++; $display("FAIL rnd_in_ready[%0d] cyc %0d got %b want %b", k, c, ir[k], q.size() < 2); end
                checks++; if (ov[k] !== (q.size() > 0)) begin errors++; $display("FAIL rnd_out_valid[%0d] cyc %0d got %b want %b", k, c, ov[k], q.size() > 0); end
                if (q.size() > 0) begin
                    checks++;
                    if (obs(k) !== model(q[0][31:0], q[0][34:32], k)) begin
                        errors++; $display("FAIL rnd_result[%0d] cyc %0d got %h want %h", k, c, obs(k), model(q[0][31:0], q[0][34:32], k));
                    end
                end
            end
            can_in = q.size() < 2;
            if (flush) q.delete();
            else begin
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (in_valid && can_in) q.push_back({fmt_ctrl, instr});
            end
        end
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
